mc_control_fsm: RTL and testbench

- Multi-cycle MIPS controller that replaces the single-cycle decoder pair once the datapath shares one ALU and one memory port across cycles.
- Decodes op/funct and walks a Moore FSM that drives the PC, IR, register-file, memory and ALU-mux enables each cycle.
- Sits between the IR/zero flag and the multi-cycle datapath.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, plus nop (sll 0).

---
 rtl/mc_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: Moore-style enables for a shared-ALU, shared-memory datapath.
// Optional performance counters (instr_cnt, cycle_cnt) are generated when MC_PERF_CNT_EN is defined.
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4 (waits FETCH_WAIT extra cycles)
// DECODE | precompute branch target into ALUOut, dispatch on op/funct
// MEMADR | effective address A + sext(imm)
// MEMRD  | data-memory read (waits MEM_WAIT extra cycles)
// MEMWB  | MDR -> GRF[rt]
// MEMWR  | data-memory write strobe for the whole wait window
// EXEC_R | addu/subu on A,B
// ALUWB  | ALUOut -> GRF[rd or rt], ALU inputs held
// EXEC_I | ori/lui on A, zext(imm)
// BRANCH | beq compare, PC <= target if zero
// JUMP   | j/jal, jal links PC (already PC+4) into $31
// JR     | PC <= A
module mc_control_fsm #(
    parameter int unsigned FETCH_WAIT = 0,
    parameter int unsigned MEM_WAIT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       EXTop,
    output logic [1:0] PCSrc,
    output logic [1:0] Memback,
    output logic [3:0] state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [31:0] cycle_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXEC_I = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JR     = 4'd11
    } state_t;

    localparam logic [3:0] FW = FETCH_WAIT[3:0];
    localparam logic [3:0] MW = MEM_WAIT[3:0];

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    state_t     cur, nxt;
    logic [3:0] cnt, cnt_nxt;

    logic is_r, is_addu, is_subu, is_jr, is_lw, is_sw, is_ori, is_lui, is_beq, is_j, is_jal;

    assign is_r    = (op == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_jr   = is_r && (funct == 6'b001000);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);

    assign state = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= S_FETCH;
            cnt <= 4'd0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        nxt        = cur;
        cnt_nxt    = 4'd0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        EXTop      = 1'b0;
        PCSrc      = 2'b00;
        Memback    = 2'b00;
        case (cur)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                if (cnt == FW) begin
                    // Held off while reset is asserted so a zero-wait fetch does not load PC/IR in reset.
                    PCWrite = !reset;
                    IRWrite = !reset;
                    nxt     = S_DECODE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                EXTop   = 1'b1;
                if (is_lw || is_sw)        nxt = S_MEMADR;
                else if (is_addu || is_subu) nxt = S_EXEC_R;
                else if (is_jr)            nxt = S_JR;
                else if (is_ori || is_lui) nxt = S_EXEC_I;
                else if (is_beq)           nxt = S_BRANCH;
                else if (is_j || is_jal)   nxt = S_JUMP;
                else                       nxt = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                EXTop   = 1'b1;
                nxt     = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (cnt == MW) nxt = S_MEMWB;
                else           cnt_nxt = cnt + 4'd1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                Memback  = 2'b01;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                if (cnt == MW) nxt = S_FETCH;
                else           cnt_nxt = cnt + 4'd1;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUControl = is_subu ? ALU_SUB : ALU_ADD;
                nxt        = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = is_lui ? ALU_LUI : ALU_OR;
                nxt        = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                ALUSrcA  = 1'b1;
                if (is_r) begin
                    RegDst     = 2'b01;
                    ALUControl = is_subu ? ALU_SUB : ALU_ADD;
                end else begin
                    ALUSrcB    = 2'b10;
                    ALUControl = is_lui ? ALU_LUI : ALU_OR;
                end
                nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCWrite    = zero;
                nxt        = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
                if (is_jal) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    Memback  = 2'b10;
                end
                nxt = S_FETCH;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
                nxt     = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt <= 32'd0;
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (nxt == S_FETCH && cur != S_FETCH) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboarded bench for mc_control_fsm: three instances with different wait parameters share the inputs.
// Expected per-cycle state and control word are queued with their stimulus and popped as the DUT steps.
module tb_mc_control_fsm;

    localparam int FW_T [3] = '{0, 0, 2};
    localparam int MW_T [3] = '{0, 2, 1};

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_ORI = 6'h0d;
    localparam logic [5:0] OP_LUI = 6'h0f;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_JR   = 6'h08;

    // {PCWrite,IRWrite,MemWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUControl,EXTop,PCSrc,Memback}
    function automatic logic [16:0] cw(input logic pcw, input logic irw, input logic mw, input logic rw,
                                       input logic [1:0] rd, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic ext, input logic [1:0] ps,
                                       input logic [1:0] mb);
        return {pcw, irw, mw, rw, rd, sa, sb, ac, ext, ps, mb};
    endfunction

    localparam logic [16:0] C_FWAIT  = cw(0,0,0,0,2'b00,0,2'b01,3'b000,0,2'b00,2'b00);
    localparam logic [16:0] C_FGO    = cw(1,1,0,0,2'b00,0,2'b01,3'b000,0,2'b00,2'b00);
    localparam logic [16:0] C_DEC    = cw(0,0,0,0,2'b00,0,2'b11,3'b000,1,2'b00,2'b00);
    localparam logic [16:0] C_MADR   = cw(0,0,0,0,2'b00,1,2'b10,3'b000,1,2'b00,2'b00);
    localparam logic [16:0] C_MRD    = 17'd0;
    localparam logic [16:0] C_MWB    = cw(0,0,0,1,2'b00,0,2'b00,3'b000,0,2'b00,2'b01);
    localparam logic [16:0] C_MWR    = cw(0,0,1,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00);
    localparam logic [16:0] C_XADD   = cw(0,0,0,0,2'b00,1,2'b00,3'b000,0,2'b00,2'b00);
    localparam logic [16:0] C_XSUB   = cw(0,0,0,0,2'b00,1,2'b00,3'b001,0,2'b00,2'b00);
    localparam logic [16:0] C_WADD   = cw(0,0,0,1,2'b01,1,2'b00,3'b000,0,2'b00,2'b00);
    localparam logic [16:0] C_WSUB   = cw(0,0,0,1,2'b01,1,2'b00,3'b001,0,2'b00,2'b00);
    localparam logic [16:0] C_XORI   = cw(0,0,0,0,2'b00,1,2'b10,3'b010,0,2'b00,2'b00);
    localparam logic [16:0] C_XLUI   = cw(0,0,0,0,2'b00,1,2'b10,3'b011,0,2'b00,2'b00);
    localparam logic [16:0] C_WORI   = cw(0,0,0,1,2'b00,1,2'b10,3'b010,0,2'b00,2'b00);
    localparam logic [16:0] C_WLUI   = cw(0,0,0,1,2'b00,1,2'b10,3'b011,0,2'b00,2'b00);
    localparam logic [16:0] C_BR1    = cw(1,0,0,0,2'b00,1,2'b00,3'b001,0,2'b01,2'b00);
    localparam logic [16:0] C_BR0    = cw(0,0,0,0,2'b00,1,2'b00,3'b001,0,2'b01,2'b00);
    localparam logic [16:0] C_J      = cw(1,0,0,0,2'b00,0,2'b00,3'b000,0,2'b10,2'b00);
    localparam logic [16:0] C_JAL    = cw(1,0,0,1,2'b10,0,2'b00,3'b000,0,2'b10,2'b10);
    localparam logic [16:0] C_JR     = cw(1,0,0,0,2'b00,0,2'b00,3'b000,0,2'b11,2'b00);

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [16:0] cw;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;

    logic       pcw [3], irw [3], mw [3], rw [3], sa [3], ext [3];
    logic [1:0] rd [3], sbs [3], ps [3], mb [3];
    logic [2:0] ac [3];
    logic [3:0] st [3];
`ifdef MC_PERF_CNT_EN
    logic [31:0] ic [3], cc [3];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_control_fsm #(.FETCH_WAIT(FW_T[g]), .MEM_WAIT(MW_T[g])) u_dut (
            .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
            .PCWrite(pcw[g]), .IRWrite(irw[g]), .MemWrite(mw[g]), .RegWrite(rw[g]),
            .RegDst(rd[g]), .ALUSrcA(sa[g]), .ALUSrcB(sbs[g]), .ALUControl(ac[g]),
            .EXTop(ext[g]), .PCSrc(ps[g]), .Memback(mb[g]), .state(st[g])
`ifdef MC_PERF_CNT_EN
            , .instr_cnt(ic[g]), .cycle_cnt(cc[g])
`endif
        );
    end

    function automatic logic [16:0] obs(input int d);
        return {pcw[d], irw[d], mw[d], rw[d], rd[d], sa[d], sbs[d], ac[d], ext[d], ps[d], mb[d]};
    endfunction

    task automatic push(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic [3:0] s, input logic [16:0] c);
        exp_t e;
        e.tag = tag; e.op = o; e.funct = f; e.zero = z; e.st = s; e.cw = c;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (st[d] !== 4'd0 || obs(d) !== C_FWAIT) begin
                miscompares++;
                $display("FAIL reset_dut%0d: state=%0d ctrl=%h, expected state=0 ctrl=%h", d, st[d], obs(d), C_FWAIT);
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (st[0] !== 4'd0 || pcw[0] !== 1'b0 || irw[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: state=%0d PCWrite=%b IRWrite=%b, expected 0/0/0", st[0], pcw[0], irw[0]);
        end
    endtask

    task automatic test_alu();
        exp_t e;
        apply_reset();
        push("addu_f", OP_R, FN_ADDU, 0, 0, C_FGO);  push("addu_d", OP_R, FN_ADDU, 0, 1, C_DEC);
        push("addu_x", OP_R, FN_ADDU, 0, 6, C_XADD); push("addu_w", OP_R, FN_ADDU, 0, 7, C_WADD);
        push("subu_f", OP_R, FN_SUBU, 0, 0, C_FGO);  push("subu_d", OP_R, FN_SUBU, 0, 1, C_DEC);
        push("subu_x", OP_R, FN_SUBU, 0, 6, C_XSUB); push("subu_w", OP_R, FN_SUBU, 0, 7, C_WSUB);
        push("ori_f", OP_ORI, 6'h15, 0, 0, C_FGO);   push("ori_d", OP_ORI, 6'h15, 0, 1, C_DEC);
        push("ori_x", OP_ORI, 6'h15, 0, 8, C_XORI);  push("ori_w", OP_ORI, 6'h15, 0, 7, C_WORI);
        push("lui_f", OP_LUI, 6'h23, 0, 0, C_FGO);   push("lui_d", OP_LUI, 6'h23, 0, 1, C_DEC);
        push("lui_x", OP_LUI, 6'h23, 0, 8, C_XLUI);  push("lui_w", OP_LUI, 6'h23, 0, 7, C_WLUI);
        push("alu_end", OP_R, 6'h00, 0, 0, C_FGO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            vectors++;
            if (st[0] !== e.st || obs(0) !== e.cw) begin
                miscompares++;
                $display("FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h", e.tag, st[0], obs(0), e.st, e.cw);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait2();
        exp_t e;
        apply_reset();
        push("lw_f", OP_LW, 6'h00, 0, 0, C_FGO);   push("lw_d", OP_LW, 6'h00, 0, 1, C_DEC);
        push("lw_a", OP_LW, 6'h00, 0, 2, C_MADR);  push("lw_r0", OP_LW, 6'h00, 0, 3, C_MRD);
        push("lw_r1", OP_LW, 6'h00, 0, 3, C_MRD);  push("lw_r2", OP_LW, 6'h00, 0, 3, C_MRD);
        push("lw_wb", OP_LW, 6'h00, 0, 4, C_MWB);  push("lw_end", OP_LW, 6'h00, 0, 0, C_FGO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            vectors++;
            if (st[1] !== e.st || obs(1) !== e.cw) begin
                miscompares++;
                $display("FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h", e.tag, st[1], obs(1), e.st, e.cw);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_wait1();
        exp_t e;
        apply_reset();
        push("sw_fw0", OP_SW, 6'h00, 0, 0, C_FWAIT); push("sw_fw1", OP_SW, 6'h00, 0, 0, C_FWAIT);
        push("sw_f", OP_SW, 6'h00, 0, 0, C_FGO);     push("sw_d", OP_SW, 6'h00, 0, 1, C_DEC);
        push("sw_a", OP_SW, 6'h00, 0, 2, C_MADR);    push("sw_w0", OP_SW, 6'h00, 0, 5, C_MWR);
        push("sw_w1", OP_SW, 6'h00, 0, 5, C_MWR);    push("sw_end", OP_SW, 6'h00, 0, 0, C_FWAIT);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            vectors++;
            if (st[2] !== e.st || obs(2) !== e.cw) begin
                miscompares++;
                $display("FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h", e.tag, st[2], obs(2), e.st, e.cw);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump();
        exp_t e;
        apply_reset();
        push("beq1_f", OP_BEQ, 6'h00, 0, 0, C_FGO);  push("beq1_d", OP_BEQ, 6'h00, 0, 1, C_DEC);
        push("beq1_b", OP_BEQ, 6'h00, 1, 9, C_BR1);  push("beq0_f", OP_BEQ, 6'h00, 1, 0, C_FGO);
        push("beq0_d", OP_BEQ, 6'h00, 1, 1, C_DEC);  push("beq0_b", OP_BEQ, 6'h00, 0, 9, C_BR0);
        push("j_f", OP_J, 6'h08, 0, 0, C_FGO);       push("j_d", OP_J, 6'h08, 0, 1, C_DEC);
        push("j_j", OP_J, 6'h08, 0, 10, C_J);        push("jal_f", OP_JAL, 6'h00, 0, 0, C_FGO);
        push("jal_d", OP_JAL, 6'h00, 0, 1, C_DEC);   push("jal_j", OP_JAL, 6'h00, 0, 10, C_JAL);
        push("jr_f", OP_R, FN_JR, 0, 0, C_FGO);      push("jr_d", OP_R, FN_JR, 0, 1, C_DEC);
        push("jr_j", OP_R, FN_JR, 0, 11, C_JR);      push("nop_f", OP_R, 6'h00, 0, 0, C_FGO);
        push("nop_d", OP_R, 6'h00, 0, 1, C_DEC);     push("unk_f", 6'h3f, 6'h21, 0, 0, C_FGO);
        push("unk_d", 6'h3f, 6'h21, 0, 1, C_DEC);    push("radd_f", OP_R, 6'h20, 0, 0, C_FGO);
        push("radd_d", OP_R, 6'h20, 0, 1, C_DEC);    push("bj_end", OP_R, 6'h00, 0, 0, C_FGO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            vectors++;
            if (st[0] !== e.st || obs(0) !== e.cw) begin
                miscompares++;
                $display("FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h", e.tag, st[0], obs(0), e.st, e.cw);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        apply_reset();
        push("mr_fw0", OP_SW, 6'h00, 0, 0, C_FWAIT); push("mr_fw1", OP_SW, 6'h00, 0, 0, C_FWAIT);
        push("mr_f", OP_SW, 6'h00, 0, 0, C_FGO);     push("mr_d", OP_SW, 6'h00, 0, 1, C_DEC);
        push("mr_a", OP_SW, 6'h00, 0, 2, C_MADR);    push("mr_w0", OP_SW, 6'h00, 0, 5, C_MWR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            vectors++;
            if (st[2] !== e.st || obs(2) !== e.cw) begin
                miscompares++;
                $display("FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h", e.tag, st[2], obs(2), e.st, e.cw);
            end
            @(negedge clk);
        end
        // Second MEMWR cycle: abort it asynchronously, between clock edges.
        reset = 1'b1;
        #1;
        vectors++;
        if (st[2] !== 4'd0 || mw[2] !== 1'b0 || rw[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_async: state=%0d MemWrite=%b RegWrite=%b, expected 0/0/0", st[2], mw[2], rw[2]);
        end
        @(posedge clk); #1;
        vectors++;
        if (st[2] !== 4'd0 || mw[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_hold: state=%0d MemWrite=%b, expected 0/0", st[2], mw[2]);
        end
        @(negedge clk);
        reset = 1'b0;
        push("mr_rw0", OP_SW, 6'h00, 0, 0, C_FWAIT); push("mr_rw1", OP_SW, 6'h00, 0, 0, C_FWAIT);
        push("mr_rgo", OP_SW, 6'h00, 0, 0, C_FGO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            #1;
            vectors++;
            if (st[2] !== e.st || obs(2) !== e.cw) begin
                miscompares++;
                $display("FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h", e.tag, st[2], obs(2), e.st, e.cw);
            end
            @(negedge clk);
        end
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        op = OP_R; funct = FN_ADDU; zero = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (ic[0] !== 32'd3 || cc[0] !== 32'd12) begin
            miscompares++;
            $display("FAIL perf_cnt: instr_cnt=%0d cycle_cnt=%0d, expected 3/12", ic[0], cc[0]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_lw_wait2();
        test_sw_wait1();
        test_branch_jump();
        test_reset_midop();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
